// File: rtl/aes_gcm_sched.sv
// Command scheduler for one AES-GCM operation: sequences the AES core and GHASH multiplier via valid/ready.
// Optional H-key caching (skip E(K,0) when the key is unchanged) is enabled by defining AES_GCM_HKEY_CACHE_EN.
module aes_gcm_sched #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic [95:0]      i_iv,
    input  logic [CNT_W-1:0] i_aad_blocks,
    input  logic [CNT_W-1:0] i_txt_blocks,
    input  logic             i_key_new,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_aes_valid,
    output logic [127:0]     o_aes_block,
    output logic [1:0]       o_aes_kind,
    input  logic             i_aes_ready,
    output logic             o_gh_valid,
    output logic [1:0]       o_gh_sel,
    output logic [127:0]     o_gh_len,
    input  logic             i_gh_ready
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_HKEY = 3'd1;
    localparam logic [2:0] S_J0   = 3'd2;
    localparam logic [2:0] S_AAD  = 3'd3;
    localparam logic [2:0] S_TXT  = 3'd4;
    localparam logic [2:0] S_LEN  = 3'd5;
    localparam logic [2:0] S_DONE = 3'd6;

    localparam logic [1:0] KIND_H  = 2'd0;
    localparam logic [1:0] KIND_J0 = 2'd1;
    localparam logic [1:0] KIND_KS = 2'd2;
    localparam logic [1:0] SEL_AAD = 2'd0;
    localparam logic [1:0] SEL_TXT = 2'd1;
    localparam logic [1:0] SEL_LEN = 2'd2;

    logic [2:0]       state_reg, state_next;
    logic [95:0]      iv_reg, iv_next;
    logic [CNT_W-1:0] a_reg, a_next;
    logic [CNT_W-1:0] t_reg, t_next;
    logic [CNT_W-1:0] aad_cnt_reg, aad_cnt_next;
    logic [CNT_W-1:0] aes_cnt_reg, aes_cnt_next;
    logic [CNT_W-1:0] gh_cnt_reg, gh_cnt_next;
    logic [31:0]      ctr_reg, ctr_next;
    logic             hkey_ok_reg, hkey_ok_next;
    logic             busy_reg, busy_next;
    logic             done_reg, done_next;
    logic             aes_valid_reg, aes_valid_next;
    logic [127:0]     aes_block_reg, aes_block_next;
    logic [1:0]       aes_kind_reg, aes_kind_next;
    logic             gh_valid_reg, gh_valid_next;
    logic [1:0]       gh_sel_reg, gh_sel_next;
    logic [127:0]     gh_len_reg, gh_len_next;

    logic             aes_fire, gh_fire, skip_hkey;
    logic [CNT_W-1:0] aad_inc, aes_cnt_inc, gh_cnt_inc;
    logic [31:0]      ctr_inc;

    assign aes_fire    = aes_valid_reg & i_aes_ready;
    assign gh_fire     = gh_valid_reg & i_gh_ready;
    assign aad_inc     = aad_cnt_reg + 1'b1;
    assign aes_cnt_inc = aes_cnt_reg + CNT_W'(aes_fire);
    assign gh_cnt_inc  = gh_cnt_reg + CNT_W'(gh_fire);
    assign ctr_inc     = ctr_reg + 32'(aes_fire);

`ifdef AES_GCM_HKEY_CACHE_EN
    // H is still held downstream if a previous run completed and the key did not change
    assign skip_hkey = hkey_ok_reg & ~i_key_new;
`else
    logic unused_cfg;
    assign skip_hkey  = 1'b0;
    assign unused_cfg = i_key_new | hkey_ok_reg;
`endif

    always_comb begin
        state_next     = state_reg;
        iv_next        = iv_reg;
        a_next         = a_reg;
        t_next         = t_reg;
        aad_cnt_next   = aad_cnt_reg;
        aes_cnt_next   = aes_cnt_reg;
        gh_cnt_next    = gh_cnt_reg;
        ctr_next       = ctr_reg;
        hkey_ok_next   = hkey_ok_reg;
        busy_next      = busy_reg;
        done_next      = 1'b0;
        aes_valid_next = aes_valid_reg;
        aes_block_next = aes_block_reg;
        aes_kind_next  = aes_kind_reg;
        gh_valid_next  = gh_valid_reg;
        gh_sel_next    = gh_sel_reg;
        gh_len_next    = gh_len_reg;

        case (state_reg)
            S_IDLE: begin
                if (i_start) begin
                    iv_next        = i_iv;
                    a_next         = i_aad_blocks;
                    t_next         = i_txt_blocks;
                    aad_cnt_next   = '0;
                    aes_cnt_next   = '0;
                    gh_cnt_next    = '0;
                    ctr_next       = 32'd2;
                    busy_next      = 1'b1;
                    aes_valid_next = 1'b1;
                    gh_len_next    = {64'(i_aad_blocks) << 7, 64'(i_txt_blocks) << 7};
                    if (skip_hkey) begin
                        state_next     = S_J0;
                        aes_block_next = {i_iv, 32'h1};
                        aes_kind_next  = KIND_J0;
                    end else begin
                        state_next     = S_HKEY;
                        aes_block_next = '0;
                        aes_kind_next  = KIND_H;
                    end
                end
            end

            S_HKEY: begin
                if (aes_fire) begin
                    state_next     = S_J0;
                    aes_block_next = {iv_reg, 32'h1};
                    aes_kind_next  = KIND_J0;
                end
            end

            S_J0: begin
                if (aes_fire) begin
                    if (a_reg != '0) begin
                        state_next     = S_AAD;
                        aes_valid_next = 1'b0;
                        gh_valid_next  = 1'b1;
                        gh_sel_next    = SEL_AAD;
                    end else if (t_reg != '0) begin
                        state_next     = S_TXT;
                        aes_block_next = {iv_reg, ctr_reg};
                        aes_kind_next  = KIND_KS;
                    end else begin
                        state_next     = S_LEN;
                        aes_valid_next = 1'b0;
                        gh_valid_next  = 1'b1;
                        gh_sel_next    = SEL_LEN;
                    end
                end
            end

            S_AAD: begin
                if (gh_fire) begin
                    aad_cnt_next = aad_inc;
                    if (aad_inc == a_reg) begin
                        if (t_reg != '0) begin
                            state_next     = S_TXT;
                            gh_valid_next  = 1'b0;
                            aes_valid_next = 1'b1;
                            aes_block_next = {iv_reg, ctr_reg};
                            aes_kind_next  = KIND_KS;
                        end else begin
                            state_next  = S_LEN;
                            gh_sel_next = SEL_LEN;
                        end
                    end
                end
            end

            S_TXT: begin
                // AES and GHASH sides advance independently; GHASH only ever trails AES
                aes_cnt_next = aes_cnt_inc;
                gh_cnt_next  = gh_cnt_inc;
                ctr_next     = ctr_inc;
                if (gh_cnt_inc == t_reg) begin
                    state_next     = S_LEN;
                    aes_valid_next = 1'b0;
                    gh_valid_next  = 1'b1;
                    gh_sel_next    = SEL_LEN;
                end else begin
                    aes_valid_next = aes_cnt_inc < t_reg;
                    aes_block_next = {iv_reg, ctr_inc};
                    gh_valid_next  = gh_cnt_inc < aes_cnt_inc;
                    gh_sel_next    = SEL_TXT;
                end
            end

            S_LEN: begin
                if (gh_fire) begin
                    state_next    = S_DONE;
                    gh_valid_next = 1'b0;
                    done_next     = 1'b1;
                end
            end

            S_DONE: begin
                state_next     = S_IDLE;
                busy_next      = 1'b0;
                hkey_ok_next   = 1'b1;
                aes_block_next = '0;
                aes_kind_next  = '0;
                gh_sel_next    = '0;
            end

            default: begin
                state_next     = S_IDLE;
                busy_next      = 1'b0;
                aes_valid_next = 1'b0;
                gh_valid_next  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            state_reg     <= S_IDLE;
            iv_reg        <= '0;
            a_reg         <= '0;
            t_reg         <= '0;
            aad_cnt_reg   <= '0;
            aes_cnt_reg   <= '0;
            gh_cnt_reg    <= '0;
            ctr_reg       <= '0;
            hkey_ok_reg   <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            aes_valid_reg <= 1'b0;
            aes_block_reg <= '0;
            aes_kind_reg  <= '0;
            gh_valid_reg  <= 1'b0;
            gh_sel_reg    <= '0;
            gh_len_reg    <= '0;
        end else begin
            state_reg     <= state_next;
            iv_reg        <= iv_next;
            a_reg         <= a_next;
            t_reg         <= t_next;
            aad_cnt_reg   <= aad_cnt_next;
            aes_cnt_reg   <= aes_cnt_next;
            gh_cnt_reg    <= gh_cnt_next;
            ctr_reg       <= ctr_next;
            hkey_ok_reg   <= hkey_ok_next;
            busy_reg      <= busy_next;
            done_reg      <= done_next;
            aes_valid_reg <= aes_valid_next;
            aes_block_reg <= aes_block_next;
            aes_kind_reg  <= aes_kind_next;
            gh_valid_reg  <= gh_valid_next;
            gh_sel_reg    <= gh_sel_next;
            gh_len_reg    <= gh_len_next;
        end
    end

    assign o_busy      = busy_reg;
    assign o_done      = done_reg;
    assign o_aes_valid = aes_valid_reg;
    assign o_aes_block = aes_block_reg;
    assign o_aes_kind  = aes_kind_reg;
    assign o_gh_valid  = gh_valid_reg;
    assign o_gh_sel    = gh_sel_reg;
    assign o_gh_len    = gh_len_reg;

endmodule
